// File: rtl/jpu_ifetch_queue.sv
// jpu_ifetch_queue: sequential instruction prefetch FIFO with redirect flush; define JPU_IFQ_STATS_EN for hit/redirect/drop counters
module jpu_ifetch_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 30
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fetch_en_i,
  input  logic [AW-1:0] fetch_addr_i,
  output logic [31:0]   inst_o,
  output logic          inst_valid_o,
  output logic          inst_err_o,
  output logic          stall_o,
  output logic          mem_req_o,
  output logic [AW-1:0] mem_addr_o,
  input  logic          mem_ack_i,
  input  logic [31:0]   mem_data_i,
  input  logic          mem_err_i
`ifdef JPU_IFQ_STATS_EN
  ,
  output logic [31:0]   hit_cnt_o,
  output logic [31:0]   redirect_cnt_o,
  output logic [15:0]   drop_cnt_o
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;
  state_t        state;
  logic [AW-1:0] fa [DEPTH];
  logic [31:0]   fd [DEPTH];
  logic          fe [DEPTH];
  logic [PW-1:0] rp, wp;
  logic [CW-1:0] count;
  logic [AW-1:0] pf_addr;
  logic          err_stop;
  logic          hit, pop, redirect, push, issue;
  assign hit      = |count & (fa[rp] == fetch_addr_i);
  assign pop      = fetch_en_i & hit;
  assign redirect = fetch_en_i & ~hit & (|count | (pf_addr != fetch_addr_i));
  assign push     = (state == WAIT) & mem_ack_i & ~redirect;
  // a redirect cycle never issues, so the new stream starts from the updated pf_addr
  assign issue    = (state == IDLE) & ~err_stop & ~redirect & (count < CW'(DEPTH));
  assign stall_o  = fetch_en_i & ~hit;
  always_ff @(posedge clk)
    if (push) begin
      fa[wp] <= mem_addr_o;
      fd[wp] <= mem_data_i;
      fe[wp] <= mem_err_i;
    end
  always_ff @(posedge clk)
    if (rst || redirect) begin
      rp    <= '0;
      wp    <= '0;
      count <= '0;
    end else begin
      rp    <= rp + PW'(pop);
      wp    <= wp + PW'(push);
      count <= count + CW'(push) - CW'(pop);
    end
  always_ff @(posedge clk)
    if (rst) begin
      inst_o       <= '0;
      inst_valid_o <= 1'b0;
      inst_err_o   <= 1'b0;
    end else begin
      inst_valid_o <= pop;
      if (pop) begin
        inst_o     <= fd[rp];
        inst_err_o <= fe[rp];
      end
    end
  always_ff @(posedge clk)
    if (rst) begin
      state      <= IDLE;
      mem_req_o  <= 1'b0;
      mem_addr_o <= '0;
      pf_addr    <= '0;
      err_stop   <= 1'b0;
    end else begin
      if (redirect) begin
        pf_addr  <= fetch_addr_i;
        err_stop <= 1'b0;
      end else if (push) begin
        pf_addr  <= pf_addr + AW'(1);
      end
      case (state)
        IDLE:
          if (issue) begin
            mem_req_o  <= 1'b1;
            mem_addr_o <= pf_addr;
            state      <= WAIT;
          end
        WAIT:
          if (mem_ack_i) begin
            mem_req_o <= 1'b0;
            state     <= IDLE;
            if (~redirect & mem_err_i) err_stop <= 1'b1;
          end else if (redirect) begin
            state <= DROP;
          end
        DROP:
          if (mem_ack_i) begin
            mem_req_o <= 1'b0;
            state     <= IDLE;
          end
        default: state <= IDLE;
      endcase
    end
`ifdef JPU_IFQ_STATS_EN
  logic drop;
  assign drop = mem_ack_i & ((state == DROP) | ((state == WAIT) & redirect));
  always_ff @(posedge clk)
    if (rst) begin
      hit_cnt_o      <= '0;
      redirect_cnt_o <= '0;
      drop_cnt_o     <= '0;
    end else begin
      hit_cnt_o      <= hit_cnt_o + 32'(pop & ~&hit_cnt_o);
      redirect_cnt_o <= redirect_cnt_o + 32'(redirect & ~&redirect_cnt_o);
      drop_cnt_o     <= drop_cnt_o + 16'(drop & ~&drop_cnt_o);
    end
`else
`endif
endmodule

// File: tb/tb_jpu_ifetch_queue.sv
// tb_jpu_ifetch_queue: directed checks of prefetch, redirect/drop, bus error, wrap, full FIFO and mid-run reset
module tb_jpu_ifetch_queue;
  localparam int AW = 30;
  logic          clk = 1'b0;
  logic          rst, fetch_en_i, mem_ack_i, mem_err_i;
  logic [AW-1:0] fetch_addr_i;
  logic [31:0]   mem_data_i;
  logic [31:0]   inst_o;
  logic          inst_valid_o, inst_err_o, stall_o, mem_req_o;
  logic [AW-1:0] mem_addr_o;
`ifdef JPU_IFQ_STATS_EN
  logic [31:0]   hit_cnt, redirect_cnt;
  logic [15:0]   drop_cnt;
`endif
  int            errors = 0, checks = 0;
  int            cyc = 0, lat = 1, stray_at = -1, wcnt = 0;
  logic          err_en = 1'b0;
  logic [AW-1:0] err_addr = '0;
  logic [32:0]   dq [$];
  int            dcyc [$];
  logic [AW-1:0] iq [$];
  logic          prev_req = 1'b0;
  int            c0, ib, db, it;

  jpu_ifetch_queue #(.DEPTH(4), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .fetch_en_i(fetch_en_i), .fetch_addr_i(fetch_addr_i),
    .inst_o(inst_o), .inst_valid_o(inst_valid_o), .inst_err_o(inst_err_o),
    .stall_o(stall_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
    .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i), .mem_err_i(mem_err_i)
`ifdef JPU_IFQ_STATS_EN
    , .hit_cnt_o(hit_cnt), .redirect_cnt_o(redirect_cnt), .drop_cnt_o(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  // bus model: word data equals its address, ack after lat cycles of request
  initial begin
    mem_ack_i = 1'b0; mem_data_i = '0; mem_err_i = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (mem_ack_i) begin
        mem_ack_i = 1'b0; mem_err_i = 1'b0; wcnt = 0;
      end else if (cyc == stray_at) begin
        mem_ack_i = 1'b1; mem_data_i = 32'hDEAD_BEEF; mem_err_i = 1'b0;
      end else if (mem_req_o) begin
        wcnt++;
        if (wcnt >= lat) begin
          mem_ack_i = 1'b1; mem_data_i = 32'(mem_addr_o);
          mem_err_i = err_en && (mem_addr_o == err_addr);
        end
      end else wcnt = 0;
    end
  end

  initial forever begin
    @(posedge clk);
    cyc++;
    #2;
    if (inst_valid_o) begin
      dq.push_back({inst_err_o, inst_o});
      dcyc.push_back(cyc);
    end
    if (mem_req_o && !prev_req) iq.push_back(mem_addr_o);
    prev_req = mem_req_o;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fetch_run(input logic [AW-1:0] start, input int n, input int maxc, output int iters);
    logic [AW-1:0] a;
    int got;
    a = start; got = 0; iters = 0;
    while (got < n && iters < maxc) begin
      fetch_en_i = 1'b1; fetch_addr_i = a;
      #1;
      if (!stall_o) begin a++; got++; end
      iters++;
      @(negedge clk);
    end
    fetch_en_i = 1'b0;
    check("fetch_done", 64'(got), 64'(n));
  endtask

  initial begin
    rst = 1'b1; fetch_en_i = 1'b0; fetch_addr_i = '0;
    repeat (3) @(negedge clk);
    check("rst_inst", 64'(inst_o), 64'(0));
    check("rst_valid", 64'(inst_valid_o), 64'(0));
    check("rst_err", 64'(inst_err_o), 64'(0));
    check("rst_req", 64'(mem_req_o), 64'(0));
    check("rst_addr", 64'(mem_addr_o), 64'(0));
    check("rst_stall", 64'(stall_o), 64'(0));
    // sequential run, latency 1
    rst = 1'b0; c0 = cyc; ib = iq.size(); db = dq.size();
    fetch_run(30'h0010_0000, 8, 80, it);
    check("seq_first_valid_lat", 64'(dcyc[db] - c0), 64'(4));
    check("seq_first_issue", 64'(iq[ib]), 64'(30'h0010_0000));
    for (int i = 0; i < 8; i++)
      check("seq_word", 64'(dq[db+i]), 64'({1'b0, 32'(32'h0010_0000 + i)}));
    lat = 3;
    repeat (30) @(negedge clk);
    check("fill_req_idle", 64'(mem_req_o), 64'(0));
    check("hold_inst", 64'(inst_o), 64'(32'h0010_0007));
    check("hold_valid", 64'(inst_valid_o), 64'(0));
    // redirect while a request is in flight
    ib = iq.size(); db = dq.size();
    fetch_en_i = 1'b1; fetch_addr_i = 30'h100;
    @(negedge clk);
    fetch_en_i = 1'b0;
    repeat (2) @(negedge clk);
    check("wait_req", 64'(mem_req_o), 64'(1));
    check("wait_addr", 64'(mem_addr_o), 64'(30'h100));
    fetch_en_i = 1'b1; fetch_addr_i = 30'h200;
    @(negedge clk);
    check("drop_req_held", 64'(mem_req_o), 64'(1));
    check("drop_addr_held", 64'(mem_addr_o), 64'(30'h100));
    fetch_run(30'h200, 1, 40, it);
    check("redir_next_issue", 64'(iq[ib+1]), 64'(30'h200));
    check("redir_first_inst", 64'(dq[db]), 64'({1'b0, 32'h200}));
`ifdef JPU_IFQ_STATS_EN
    check("stat_hit", 64'(hit_cnt), 64'(9));
    check("stat_redirect", 64'(redirect_cnt), 64'(3));
    check("stat_drop", 64'(drop_cnt), 64'(1));
`endif
    // bus error on word 0x10 stops prefetch until a redirect
    lat = 1; err_en = 1'b1; err_addr = 30'h10;
    ib = iq.size(); db = dq.size();
    fetch_run(30'h0E, 3, 60, it);
    check("err_w0", 64'(dq[db]), 64'({1'b0, 32'h0E}));
    check("err_w1", 64'(dq[db+1]), 64'({1'b0, 32'h0F}));
    check("err_w2", 64'(dq[db+2]), 64'({1'b1, 32'h10}));
    repeat (10) @(negedge clk);
    check("err_req_low", 64'(mem_req_o), 64'(0));
    check("err_issue_cnt", 64'(iq.size() - ib), 64'(3));
    err_en = 1'b0;
    ib = iq.size(); db = dq.size();
    fetch_run(30'h40, 1, 40, it);
    check("err_resume_addr", 64'(iq[ib]), 64'(30'h40));
    check("err_resume_inst", 64'(dq[db]), 64'({1'b0, 32'h40}));
    // address wrap-around
    ib = iq.size(); db = dq.size();
    fetch_run(30'h3FFF_FFFE, 3, 60, it);
    check("wrap_a0", 64'(iq[ib]), 64'(30'h3FFF_FFFE));
    check("wrap_a1", 64'(iq[ib+1]), 64'(30'h3FFF_FFFF));
    check("wrap_a2", 64'(iq[ib+2]), 64'(30'h0));
    check("wrap_d0", 64'(dq[db]), 64'({1'b0, 32'h3FFF_FFFE}));
    check("wrap_d1", 64'(dq[db+1]), 64'({1'b0, 32'h3FFF_FFFF}));
    check("wrap_d2", 64'(dq[db+2]), 64'({1'b0, 32'h0}));
    // full FIFO: core idle for 20 cycles
    ib = iq.size();
    fetch_en_i = 1'b1; fetch_addr_i = 30'h500;
    @(negedge clk);
    fetch_en_i = 1'b0;
    repeat (20) @(negedge clk);
    check("full_issue_cnt", 64'(iq.size() - ib), 64'(4));
    check("full_last_addr", 64'(iq[ib+3]), 64'(30'h503));
    check("full_req_low", 64'(mem_req_o), 64'(0));
    db = dq.size();
    fetch_run(30'h500, 4, 10, it);
    check("full_b2b_cycles", 64'(it), 64'(4));
    for (int i = 0; i < 4; i++)
      check("full_word", 64'(dq[db+i]), 64'({1'b0, 32'(32'h500 + i)}));
    // reset while WAIT, stray ack 2 cycles later
    lat = 3;
    repeat (30) @(negedge clk);
    fetch_en_i = 1'b1; fetch_addr_i = 30'h700;
    @(negedge clk);
    fetch_en_i = 1'b0;
    @(negedge clk);
    check("rst_pre_req", 64'(mem_req_o), 64'(1));
    check("rst_pre_addr", 64'(mem_addr_o), 64'(30'h700));
    rst = 1'b1; stray_at = cyc + 2;
    @(negedge clk);
    check("mid_rst_inst", 64'(inst_o), 64'(0));
    check("mid_rst_valid", 64'(inst_valid_o), 64'(0));
    check("mid_rst_err", 64'(inst_err_o), 64'(0));
    check("mid_rst_req", 64'(mem_req_o), 64'(0));
    check("mid_rst_addr", 64'(mem_addr_o), 64'(0));
`ifdef JPU_IFQ_STATS_EN
    check("mid_rst_hit_cnt", 64'(hit_cnt), 64'(0));
    check("mid_rst_redir_cnt", 64'(redirect_cnt), 64'(0));
    check("mid_rst_drop_cnt", 64'(drop_cnt), 64'(0));
`endif
    rst = 1'b0; fetch_en_i = 1'b1; fetch_addr_i = 30'h900;
    ib = iq.size(); db = dq.size();
    #1;
    check("post_rst_stall", 64'(stall_o), 64'(1));
    @(negedge clk);
    check("post_rst_no_issue", 64'(mem_req_o), 64'(0));
    @(negedge clk);
    check("stray_ack_ignored_req", 64'(mem_req_o), 64'(1));
    check("stray_ack_ignored_addr", 64'(mem_addr_o), 64'(30'h900));
    fetch_run(30'h900, 1, 40, it);
    check("post_rst_inst", 64'(dq[db]), 64'({1'b0, 32'h900}));
    check("post_rst_deliv_cnt", 64'(dq.size() - db), 64'(1));
    check("post_rst_issue", 64'(iq[ib]), 64'(30'h900));
`ifdef JPU_IFQ_STATS_EN
    check("post_rst_hit_cnt", 64'(hit_cnt), 64'(1));
    check("post_rst_redir_cnt", 64'(redirect_cnt), 64'(1));
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/jpu_ifetch_queue.md
Name: jpu_ifetch_queue

Overview:
- Instruction prefetch queue between the core's fetch port and the instruction-side memory bus.
- Prefetches sequential instruction words into a DEPTH-entry FIFO ahead of the core, so straight-line code runs at one instruction per cycle despite multi-cycle bus latency.
- A fetch address that does not match the queue head (jump, branch, exception, eret) flushes the queue and restarts prefetch at the new address.
- Any response still in flight at the time of a flush is discarded.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- AW, 30, word-address width (byte address bits [31:2]).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- fetch_en_i  in  1  core requests the instruction at fetch_addr_i this cycle
- fetch_addr_i  in  AW  requested word address
- inst_o  out  32  instruction word, registered
- inst_valid_o  out  1  inst_o valid; single-cycle pulse per delivered word
- inst_err_o  out  1  delivered word carries a bus error; qualified by inst_valid_o
- stall_o  out  1  combinational; fetch_en_i & ~hit, core must hold fetch_addr_i
- mem_req_o  out  1  bus read request; held high until mem_ack_i
- mem_addr_o  out  AW  bus read word address; stable while mem_req_o is high
- mem_ack_i  in  1  response strobe; may assert in the cycle after mem_req_o rises or later
- mem_data_i  in  32  read data; valid with mem_ack_i
- mem_err_i  in  1  bus error; valid with mem_ack_i

Behaviour:
- Reset values:
  - inst_o = 0, inst_valid_o = 0, inst_err_o = 0, mem_req_o = 0, mem_addr_o = 0.
  - FIFO count = 0, pf_addr = 0, state = IDLE.
- Each FIFO entry holds {addr[AW-1:0], data[31:0], err}. Read and write pointers are log2(DEPTH) bits and wrap naturally.
- Bus ordering: at most one outstanding bus request.
- Issue condition: a request may issue when (count + outstanding) < DEPTH.
- Hit definition: count != 0 & head.addr == fetch_addr_i.
  - On fetch_en_i & hit: pop the head. Next cycle inst_o = head.data, inst_err_o = head.err, inst_valid_o = 1.
  - Otherwise inst_valid_o = 0 next cycle and inst_o holds its value.
- Redirect definition: fetch_en_i & ~hit & (count != 0 | pf_addr != fetch_addr_i).
  - Same cycle: FIFO count <= 0 and pf_addr <= fetch_addr_i.
  - Any outstanding request is marked for drop.
  - A miss while count == 0 and pf_addr == fetch_addr_i is not a redirect; it just waits.
- State machine:
  - IDLE:
    - If the issue condition holds and no error is latched: mem_req_o <= 1, mem_addr_o <= pf_addr, go to WAIT.
  - WAIT:
    - On mem_ack_i with no redirect: push {mem_addr_o, mem_data_i, mem_err_i}, pf_addr <= pf_addr + 1, mem_req_o <= 0.
    - If mem_err_i: latch err_stop and go to IDLE. Prefetch is suppressed until a redirect.
    - Otherwise go to IDLE. Back-to-back issue the following cycle is allowed.
    - Redirect without mem_ack_i: go to DROP; mem_req_o stays high (the request cannot be withdrawn).
    - Redirect in the same cycle as mem_ack_i: data is discarded, go to IDLE.
  - DROP:
    - On mem_ack_i: discard data and error, mem_req_o <= 0, go to IDLE.
    - Further redirects while in DROP only update pf_addr.
- Redirect always clears err_stop.
- Simultaneous events:
  - Pop and push in the same cycle: count unchanged.
  - A push is never lost. The issue condition guarantees a slot exists when the ack arrives.
- Address arithmetic: pf_addr + 1 is modulo 2^AW, so 0x3FFFFFFF wraps to 0x00000000.
- Reset mid-operation:
  - All state cleared immediately.
  - An ack for a pre-reset request arriving after reset is ignored in IDLE. The bus must tolerate mem_req_o dropping.
- Latency:
  - Cold miss: request the cycle after the redirect, ack after L cycles, hit the following cycle, inst_valid_o one cycle later.
  - Steady-state hits: 1 instruction/cycle while the FIFO is non-empty.

Optional Feature:
- Macro: JPU_IFQ_STATS_EN.
- When defined, adds output ports:
  - hit_cnt_o [31:0]: counts fetch_en_i & hit.
  - redirect_cnt_o [31:0]: counts redirects.
  - drop_cnt_o [15:0]: counts discarded acks.
- All counters saturate at all-ones and reset to 0.
- When undefined, these ports and counters are absent. Core behaviour is identical.

Test Plan:
- Sequential run:
  - Stimulus: reset, fetch 0x00100000 onward every cycle, bus latency 1, memory word = address.
  - Response: first inst_valid_o 4 cycles after the first fetch_en_i; then 8 consecutive words 0x00100000..0x00100007 with no stall_o gaps once the FIFO is primed.
- Redirect with in-flight request:
  - Stimulus: latency 3; redirect to 0x200 while in WAIT.
  - Response: state goes to DROP; the late ack is discarded (drop_cnt_o = 1); the next mem_addr_o is 0x200; the first delivered inst = word 0x200.
- Bus error:
  - Stimulus: mem_err_i on address 0x10.
  - Response: the word is delivered with inst_err_o = 1 and mem_req_o stays 0 afterwards. After a redirect to 0x40, prefetch resumes with mem_addr_o = 0x40.
- Wrap-around:
  - Stimulus: start at 0x3FFFFFFE.
  - Response: mem_addr_o sequence 0x3FFFFFFE, 0x3FFFFFFF, 0x00000000; delivered in order.
- Full FIFO:
  - Stimulus: DEPTH = 4, core holds fetch_en_i = 0 for 20 cycles.
  - Response: exactly 4 requests issue; mem_req_o stays low afterwards; then 4 back-to-back hits.
- Reset mid-operation:
  - Stimulus: assert rst in WAIT; the ack arrives 2 cycles later.
  - Response: all outputs 0; the ack is ignored; count = 0; no push.
